// File: rtl/gpio_reg_master.sv
// Register-port initiator for the GPIO register block.
// It runs one read, write, set-bits or clear-bits transaction per command and returns one response.
module gpio_reg_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_addr,
  input  logic [3:0]  cmd_wben,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  addr,
  output logic [3:0]  wben,
  output logic        r_wn,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  // A latency of 0 is treated as 1, and the 3-bit counter caps it at 7.
  localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > 7) ? 7 : RD_LAT);
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        clr_reg, clr_next;
  logic [3:0]  wben_lat_reg, wben_lat_next;
  logic [31:0] mask_reg, mask_next;
  logic        cmd_ready_next, rsp_valid_next, r_wn_next;
  logic [31:0] rsp_rdata_next, wdata_next;
  logic [2:0]  addr_next;
  logic [3:0]  wben_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      clr_reg      <= 1'b0;
      wben_lat_reg <= 4'd0;
      mask_reg     <= 32'd0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      addr         <= 3'd0;
      wben         <= 4'd0;
      r_wn         <= 1'b1;
      wdata        <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      clr_reg      <= clr_next;
      wben_lat_reg <= wben_lat_next;
      mask_reg     <= mask_next;
      cmd_ready    <= cmd_ready_next;
      rsp_valid    <= rsp_valid_next;
      rsp_rdata    <= rsp_rdata_next;
      addr         <= addr_next;
      wben         <= wben_next;
      r_wn         <= r_wn_next;
      wdata        <= wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    clr_next       = clr_reg;
    wben_lat_next  = wben_lat_reg;
    mask_next      = mask_reg;
    cmd_ready_next = cmd_ready;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    addr_next      = addr;
    // The bus falls back to idle unless a write strobe is launched this cycle.
    wben_next      = 4'd0;
    r_wn_next      = 1'b1;
    wdata_next     = 32'd0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_ready_next = 1'b0;
          addr_next      = cmd_addr;
          clr_next       = cmd_op[0];
          wben_lat_next  = cmd_wben;
          mask_next      = cmd_wdata;
          cnt_next       = CNT_INIT;
          case (cmd_op)
            2'b00: state_next = RD;
            2'b01: begin
              state_next = WR;
              r_wn_next  = 1'b0;
              wben_next  = cmd_wben;
              wdata_next = cmd_wdata;
            end
            default: state_next = RMW_RD;
          endcase
        end
      end
      RD: begin
        if (cnt_reg == 3'd0) begin
          rsp_rdata_next = rdata;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      WR: begin
        rsp_rdata_next = 32'd0;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RMW_RD: begin
        if (cnt_reg == 3'd0) begin
          // The pre-modify value is parked in rsp_rdata; it becomes the response.
          rsp_rdata_next = rdata;
          r_wn_next      = 1'b0;
          wben_next      = wben_lat_reg;
          wdata_next     = clr_reg ? (rdata & ~mask_reg) : (rdata | mask_reg);
          state_next     = RMW_WR;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      RMW_WR: begin
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpio_reg_master.sv
// Bench for gpio_reg_master: two instances (RD_LAT=1 and RD_LAT=3) share the command stream,
// each backed by its own byte-enabled register file model.
module tb_gpio_reg_master;

  logic        clk, reset;
  logic        cmd_valid, rsp_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [3:0]  cmd_wben;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_ready, rsp_valid, r_wn;
  logic [31:0] rsp_rdata [2];
  logic [2:0]  addr [2];
  logic [3:0]  wben [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  bit   [31:0] mem [2][8];
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
    logic [31:0] exp_rsp;
    logic [31:0] exp_bus;
  } vec_t;
  vec_t vecs [14];

  gpio_reg_master #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wben(cmd_wben), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]),
    .addr(addr[0]), .wben(wben[0]), .r_wn(r_wn[0]), .wdata(wdata[0]), .rdata(rdata[0])
  );

  gpio_reg_master #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wben(cmd_wben), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]),
    .addr(addr[1]), .wben(wben[1]), .r_wn(r_wn[1]), .wdata(wdata[1]), .rdata(rdata[1])
  );

  assign rdata[0] = mem[0][addr[0]];
  assign rdata[1] = mem[1][addr[1]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (!r_wn[d])
        for (int b = 0; b < 4; b++)
          if (wben[d][b]) mem[d][addr[d]][8*b +: 8] <= wdata[d][8*b +: 8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int d, input logic [1:0] op);
    int l;
    l = (d == 0) ? 1 : 3;
    if (op == 2'b00) return l + 1;
    if (op == 2'b01) return 2;
    return l + 2;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready != 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'b0, cmd_ready == 2'b11}, 32'h1);
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int          first [2];
    int          nstb [2];
    logic [31:0] rr [2];
    logic [31:0] sw [2];
    logic [3:0]  sb [2];
    logic [2:0]  sa [2];
    wait_idle();
    cmd_op = v.op; cmd_addr = v.addr; cmd_wben = v.wben; cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      first[d] = 0; nstb[d] = 0; rr[d] = '0; sw[d] = '0; sb[d] = '0; sa[d] = '0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!r_wn[d]) begin
          nstb[d]++; sw[d] = wdata[d]; sb[d] = wben[d]; sa[d] = addr[d];
        end
        if (rsp_valid[d] && first[d] == 0) begin
          first[d] = k; rr[d] = rsp_rdata[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("v%0d_d%0d_lat", idx, d), 32'(first[d]), 32'(exp_lat(d, v.op)));
      chk($sformatf("v%0d_d%0d_rsp", idx, d), rr[d], v.exp_rsp);
      chk($sformatf("v%0d_d%0d_nstb", idx, d), 32'(nstb[d]), (v.op == 2'b00) ? 32'd0 : 32'd1);
      if (v.op != 2'b00) begin
        chk($sformatf("v%0d_d%0d_bus_wdata", idx, d), sw[d], v.exp_bus);
        chk($sformatf("v%0d_d%0d_bus_wben", idx, d), {28'b0, sb[d]}, {28'b0, v.wben});
        chk($sformatf("v%0d_d%0d_bus_addr", idx, d), {29'b0, sa[d]}, {29'b0, v.addr});
      end
    end
    $display("txn %0d op=%0d addr=%0d rsp=%h/%h lat=%0d/%0d", idx, v.op, v.addr,
             rr[0], rr[1], first[0], first[1]);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 3'd6, 4'b0011, 32'h0000_8001, 32'h0000_0000, 32'h0000_8001};
    vecs[1]  = '{2'b00, 3'd6, 4'b0000, 32'h0000_0000, 32'h0000_8001, 32'h0000_0000};
    vecs[2]  = '{2'b10, 3'd6, 4'b1111, 32'h0000_0006, 32'h0000_8001, 32'h0000_8007};
    vecs[3]  = '{2'b11, 3'd6, 4'b1111, 32'h0000_8000, 32'h0000_8007, 32'h0000_0007};
    vecs[4]  = '{2'b00, 3'd6, 4'b0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000};
    vecs[5]  = '{2'b01, 3'd1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[6]  = '{2'b01, 3'd1, 4'b0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
    vecs[7]  = '{2'b00, 3'd1, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[8]  = '{2'b01, 3'd1, 4'b0100, 32'h00AA_0000, 32'h0000_0000, 32'h00AA_0000};
    vecs[9]  = '{2'b00, 3'd1, 4'b0000, 32'h0000_0000, 32'hDEAA_BEEF, 32'h0000_0000};
    vecs[10] = '{2'b10, 3'd1, 4'b1000, 32'h2100_0000, 32'hDEAA_BEEF, 32'hFFAA_BEEF};
    vecs[11] = '{2'b00, 3'd1, 4'b0000, 32'h0000_0000, 32'hFFAA_BEEF, 32'h0000_0000};
    vecs[12] = '{2'b11, 3'd1, 4'b0001, 32'h0000_00FF, 32'hFFAA_BEEF, 32'hFFAA_BE00};
    vecs[13] = '{2'b00, 3'd1, 4'b0000, 32'h0000_0000, 32'hFFAA_BE00, 32'h0000_0000};

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = 2'b00; cmd_addr = 3'd0; cmd_wben = 4'd0; cmd_wdata = 32'd0;
    #10 reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk($sformatf("reset_state_d%0d_c%0d", d, k),
            {cmd_ready[d], rsp_valid[d], r_wn[d], wben[d], addr[d], 20'b0}, {3'b101, 4'b0, 3'b0, 20'b0});
      chk($sformatf("reset_data_c%0d", k), rsp_rdata[0] | rsp_rdata[1] | wdata[0] | wdata[1], 32'd0);
    end

    for (int i = 0; i < 14; i++) run_cmd(vecs[i], i);

    // Response back-pressure with the next command already waiting.
    wait_idle();
    rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 3'd6; cmd_wben = 4'd0; cmd_wdata = 32'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 2'b01; cmd_addr = 3'd2; cmd_wben = 4'b1111; cmd_wdata = 32'h0000_0055;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_strobe_c%0d", k), {30'b0, r_wn}, 32'd3);
      chk($sformatf("bp_busy_c%0d", k), {30'b0, cmd_ready}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("bp_hold_d%0d_c%0d", d, k), {29'b0, rsp_valid[d], cmd_ready[d], r_wn[d]}, 32'b101);
        chk($sformatf("bp_rdata_d%0d_c%0d", d, k), rsp_rdata[d], 32'h0000_0007);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs", {28'b0, rsp_valid, cmd_ready}, 32'b0011);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_next_strobe_d%0d", d), {28'b0, r_wn[d], addr[d]}, 32'b0010);
      chk($sformatf("bp_next_wdata_d%0d", d), wdata[d], 32'h0000_0055);
    end
    cmd_valid = 1'b0;
    wait_idle();
    for (int d = 0; d < 2; d++) chk($sformatf("bp_mem2_d%0d", d), mem[d][2], 32'h0000_0055);
    $display("txn bp read+held write done");

    // Reset in the middle of a write strobe.
    wait_idle();
    cmd_op = 2'b01; cmd_addr = 3'd3; cmd_wben = 4'b1111; cmd_wdata = 32'hA5A5_A5A5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_strobe_seen", {30'b0, r_wn}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ctrl", {26'b0, r_wn, cmd_ready, rsp_valid}, 32'b111100);
    chk("rst_async_wben", {24'b0, wben[0], wben[1]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rsp_c%0d", k), {30'b0, rsp_valid}, 32'd0);
    end
    for (int d = 0; d < 2; d++) chk($sformatf("rst_mem3_d%0d", d), mem[d][3], 32'd0);
    $display("txn reset during write done");

    run_cmd(vecs[4], 14);
    run_cmd(vecs[13], 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
